// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS CPU Avalon bus front end.
package mips_bus_pkg;

   typedef enum logic [1:0] {IDLE, INSTR, DATA, DONE} bus_state_e;

   localparam logic [3:0]  BYTEEN_WORD      = 4'b1111;
   localparam logic [31:0] ABORT_DATA_DEF   = 32'hDEAD_BEEF;

endpackage

// File: rtl/mips_cpu_bus_arbiter.sv
// Serialises core fetch and load/store requests onto one Avalon-MM master port,
// with a waitrequest watchdog that aborts stuck transfers.
module mips_cpu_bus_arbiter
   import mips_bus_pkg::*;
#(
   parameter int          WAIT_TIMEOUT = 64,
   parameter logic [31:0] ABORT_DATA   = ABORT_DATA_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_req,
   input  logic [31:0] instr_addr,
   output logic [31:0] instr_rdata,
   output logic        instr_ready,
   input  logic        data_read,
   input  logic        data_write,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   input  logic [3:0]  data_byteenable,
   output logic [31:0] data_rdata,
   output logic        data_ready,
   output logic        bus_error,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic [31:0] readdata,
   input  logic        waitrequest
);

   localparam int WD_W = $clog2(WAIT_TIMEOUT + 1);

   bus_state_e      state;
   logic [WD_W-1:0] wd_cnt;
   logic [WD_W-1:0] wd_next;

   assign wd_next = wd_cnt + 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         wd_cnt      <= '0;
         instr_rdata <= '0;
         instr_ready <= 1'b0;
         data_rdata  <= '0;
         data_ready  <= 1'b0;
         bus_error   <= 1'b0;
         address     <= '0;
         read        <= 1'b0;
         write       <= 1'b0;
         writedata   <= '0;
         byteenable  <= '0;
      end else begin
         instr_ready <= 1'b0;
         data_ready  <= 1'b0;
         case (state)
            IDLE: begin
               wd_cnt <= '0;
               // Data port wins; a simultaneous read+write is treated as a write.
               if (data_write || data_read) begin
                  state      <= DATA;
                  address    <= {data_addr[31:2], 2'b00};
                  write      <= data_write;
                  read       <= ~data_write;
                  byteenable <= data_byteenable;
                  writedata  <= data_wdata;
               end else if (instr_req) begin
                  state      <= INSTR;
                  address    <= {instr_addr[31:2], 2'b00};
                  read       <= 1'b1;
                  write      <= 1'b0;
                  byteenable <= BYTEEN_WORD;
               end
            end
            INSTR, DATA: begin
               if (!waitrequest) begin
                  read  <= 1'b0;
                  write <= 1'b0;
                  state <= DONE;
                  if (state == INSTR) begin
                     instr_rdata <= readdata;
                     instr_ready <= 1'b1;
                  end else begin
                     if (read) data_rdata <= readdata;
                     data_ready <= 1'b1;
                  end
               end else begin
                  wd_cnt <= wd_next;
                  if (wd_next == WD_W'(WAIT_TIMEOUT)) begin
                     read      <= 1'b0;
                     write     <= 1'b0;
                     bus_error <= 1'b1;
                     state     <= DONE;
                     if (state == INSTR) begin
                        instr_rdata <= ABORT_DATA;
                        instr_ready <= 1'b1;
                     end else begin
                        if (read) data_rdata <= ABORT_DATA;
                        data_ready <= 1'b1;
                     end
                  end
               end
            end
            // One dead cycle so a request still held high is not re-sampled on completion.
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Scoreboard bench: stimulus queues expected bus transfers and completions,
// negedge monitors pop and compare whenever the DUT presents them.
module tb_mips_cpu_bus_arbiter;
   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        instr_req = 1'b0;
   logic [31:0] instr_addr = '0;
   logic [31:0] instr_rdata;
   logic        instr_ready;
   logic        data_read = 1'b0;
   logic        data_write = 1'b0;
   logic [31:0] data_addr = '0;
   logic [31:0] data_wdata = '0;
   logic [3:0]  data_byteenable = '0;
   logic [31:0] data_rdata;
   logic        data_ready;
   logic        bus_error;
   logic [31:0] address;
   logic        read, write;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic [31:0] readdata = '0;
   logic        waitrequest = 1'b0;

   mips_cpu_bus_arbiter #(.WAIT_TIMEOUT(TO), .ABORT_DATA(32'hDEAD_BEEF)) dut (
      .clk(clk), .reset(reset),
      .instr_req(instr_req), .instr_addr(instr_addr), .instr_rdata(instr_rdata), .instr_ready(instr_ready),
      .data_read(data_read), .data_write(data_write), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_byteenable(data_byteenable), .data_rdata(data_rdata), .data_ready(data_ready),
      .bus_error(bus_error), .address(address), .read(read), .write(write), .writedata(writedata),
      .byteenable(byteenable), .readdata(readdata), .waitrequest(waitrequest)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        rd;
      logic        wr;
      logic [3:0]  be;
      logic [31:0] wd;
   } bus_exp_t;

   typedef struct {
      logic        is_instr;
      logic [31:0] rdata;
   } cmp_exp_t;

   bus_exp_t bus_q[$];
   cmp_exp_t cmp_q[$];
   int       start_q[$];
   int       rdy_q[$];

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic exp_bus(input logic [31:0] a, input logic rd, input logic wr,
                          input logic [3:0] be, input logic [31:0] wd);
      bus_exp_t e;
      e.addr = a; e.rd = rd; e.wr = wr; e.be = be; e.wd = wd;
      bus_q.push_back(e);
   endtask

   task automatic exp_cmp(input logic is_instr, input logic [31:0] rdata);
      cmp_exp_t e;
      e.is_instr = is_instr; e.rdata = rdata;
      cmp_q.push_back(e);
   endtask

   // Bus monitor: a new transfer pops an expectation; a continuing one must hold still.
   logic        prev_strobe = 1'b0;
   logic [69:0] prev_bus = '0;
   logic [69:0] cur_bus;
   logic        prev_rdy = 1'b0;
   always @(negedge clk) begin
      bus_exp_t be_e;
      cmp_exp_t ce;
      cur_bus = {address, read, write, byteenable, (write ? writedata : 32'h0)};
      if (read || write) begin
         if (!prev_strobe) begin
            start_q.push_back(cyc);
            if (bus_q.size() == 0) chk("bus_unexpected", 96'(cur_bus), 96'h0);
            else begin
               be_e = bus_q.pop_front();
               chk("bus_xfer", 96'(cur_bus),
                   96'({be_e.addr, be_e.rd, be_e.wr, be_e.be, (be_e.wr ? be_e.wd : 32'h0)}));
            end
         end else chk("bus_stable", 96'(cur_bus), 96'(prev_bus));
      end
      if (instr_ready || data_ready) begin
         rdy_q.push_back(cyc);
         chk("ready_excl", 96'(instr_ready && data_ready), 96'h0);
         chk("ready_pulse", 96'(prev_rdy), 96'h0);
         if (cmp_q.size() == 0) chk("cmp_unexpected", 96'({instr_ready, data_ready}), 96'h0);
         else begin
            ce = cmp_q.pop_front();
            if (ce.is_instr) chk("instr_cmp", 96'({instr_ready, instr_rdata}), 96'({1'b1, ce.rdata}));
            else             chk("data_cmp",  96'({data_ready, data_rdata}),   96'({1'b1, ce.rdata}));
         end
      end
      prev_strobe = read || write;
      prev_bus    = cur_bus;
      prev_rdy    = instr_ready || data_ready;
   end

   initial begin
      // Reset state
      tick(2);
      chk("rst_bus", 96'({address, read, write, writedata, byteenable}), 96'h0);
      chk("rst_rdata", 96'({instr_rdata, data_rdata}), 96'h0);
      chk("rst_flags", 96'({instr_ready, data_ready, bus_error}), 96'h0);
      reset = 1'b0;
      tick(1);

      // Single fetch, zero wait
      exp_bus(32'hBFC0_0000, 1'b1, 1'b0, 4'hF, 32'h0);
      exp_cmp(1'b1, 32'h2402_0005);
      readdata = 32'h2402_0005; instr_addr = 32'hBFC0_0000; instr_req = 1'b1;
      tick(1); instr_req = 1'b0;
      chk("fetch_strobe", 96'({read, address}), 96'({1'b1, 32'hBFC0_0000}));
      tick(1);
      chk("fetch_done", 96'({read, instr_ready}), 96'({1'b0, 1'b1}));
      tick(1);
      chk("fetch_ready_drop", 96'(instr_ready), 96'h0);
      tick(2);

      // Simultaneous fetch and store: store first, then fetch
      exp_bus(32'h0000_1000, 1'b0, 1'b1, 4'b1000, 32'h0000_00AB);
      exp_cmp(1'b0, 32'h0);
      exp_bus(32'h0000_2000, 1'b1, 1'b0, 4'hF, 32'h0);
      exp_cmp(1'b1, 32'h1357_2468);
      readdata = 32'h1357_2468;
      instr_req = 1'b1; instr_addr = 32'h2000;
      data_write = 1'b1; data_addr = 32'h1003; data_wdata = 32'hAB; data_byteenable = 4'b1000;
      tick(1); data_write = 1'b0;
      tick(3); instr_req = 1'b0;
      tick(4);

      // Load stalled 5 cycles
      start_q.delete(); rdy_q.delete();
      exp_bus(32'h0000_0040, 1'b1, 1'b0, 4'hF, 32'h0);
      exp_cmp(1'b0, 32'hCAFE_F00D);
      readdata = 32'h0BAD_F00D; waitrequest = 1'b1;
      data_read = 1'b1; data_addr = 32'h42; data_byteenable = 4'hF;
      tick(1); data_read = 1'b0;
      tick(5); waitrequest = 1'b0; readdata = 32'hCAFE_F00D;
      tick(4);
      if (start_q.size() > 0 && rdy_q.size() > 0)
         chk("stall_latency", 96'(rdy_q[0] - start_q[0]), 96'd6);
      else chk("stall_seen", 96'({start_q.size(), rdy_q.size()}), 96'({32'd1, 32'd1}));

      // Held fetch request: one read per three cycles
      start_q.delete(); rdy_q.delete();
      readdata = 32'h1111_0000;
      for (int i = 0; i < 3; i++) begin
         exp_bus(32'h0000_0500, 1'b1, 1'b0, 4'hF, 32'h0);
         exp_cmp(1'b1, 32'h1111_0000);
      end
      instr_addr = 32'h500; instr_req = 1'b1;
      tick(7); instr_req = 1'b0;
      tick(5);
      chk("held_count", 96'(start_q.size()), 96'd3);
      if (start_q.size() >= 3) begin
         chk("held_gap0", 96'(start_q[1] - start_q[0]), 96'd3);
         chk("held_gap1", 96'(start_q[2] - start_q[1]), 96'd3);
      end
      chk("no_error_yet", 96'(bus_error), 96'h0);

      // Watchdog abort on stuck waitrequest
      start_q.delete(); rdy_q.delete();
      exp_bus(32'h0000_0080, 1'b1, 1'b0, 4'hF, 32'h0);
      exp_cmp(1'b0, 32'hDEAD_BEEF);
      readdata = 32'h1234_5678; waitrequest = 1'b1;
      data_read = 1'b1; data_addr = 32'h80;
      tick(1); data_read = 1'b0;
      tick(12);
      if (start_q.size() > 0 && rdy_q.size() > 0)
         chk("abort_latency", 96'(rdy_q[0] - start_q[0]), 96'(TO));
      else chk("abort_seen", 96'({start_q.size(), rdy_q.size()}), 96'({32'd1, 32'd1}));
      chk("abort_state", 96'({bus_error, read, write}), 96'({1'b1, 1'b0, 1'b0}));
      waitrequest = 1'b0;
      tick(3);
      chk("error_sticky", 96'(bus_error), 96'h1);

      // Reset in the middle of a stalled fetch
      exp_bus(32'h0000_0300, 1'b1, 1'b0, 4'hF, 32'h0);
      waitrequest = 1'b1; instr_addr = 32'h300; instr_req = 1'b1;
      tick(1); instr_req = 1'b0;
      tick(2);
      chk("pre_reset_read", 96'({read, address}), 96'({1'b1, 32'h300}));
      #2 reset = 1'b1;
      #1;
      chk("async_reset", 96'({read, address, instr_ready, bus_error}), 96'h0);
      tick(1); reset = 1'b0; waitrequest = 1'b0;
      tick(1);
      exp_bus(32'h0000_0400, 1'b1, 1'b0, 4'hF, 32'h0);
      exp_cmp(1'b1, 32'h0F0F_0F0F);
      readdata = 32'h0F0F_0F0F; instr_addr = 32'h400; instr_req = 1'b1;
      tick(1); instr_req = 1'b0;
      tick(4);

      chk("bus_q_drained", 96'(bus_q.size()), 96'h0);
      chk("cmp_q_drained", 96'(cmp_q.size()), 96'h0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/mips_cpu_bus_arbiter.md
# mips_cpu_bus_arbiter

Avalon-MM master front end of the bus-based MIPS CPU: accepts instruction-fetch requests and data load/store requests from the multicycle core and serialises them onto the single shared Avalon port (address/read/write/byteenable/writedata/readdata/waitrequest). It sits between the core datapath and the memory slave, honours waitrequest, and registers returned data. It also enforces a waitrequest watchdog.

## Interface
- WAIT_TIMEOUT, default 64: maximum consecutive waitrequest cycles before a transaction is aborted.
- ABORT_DATA, default 32'hDEAD_BEEF: rdata returned on an aborted read.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_req  in  1  core requests a fetch.
- instr_addr  in  32  fetch byte address.
- instr_rdata  out  32  fetched word, valid while instr_ready=1.
- instr_ready  out  1  one-cycle fetch-complete pulse.
- data_read  in  1  core requests a load.
- data_write  in  1  core requests a store.
- data_addr  in  32  load/store byte address.
- data_wdata  in  32  store data, already lane-aligned.
- data_byteenable  in  4  store/load lane enables.
- data_rdata  out  32  loaded word, valid while data_ready=1.
- data_ready  out  1  one-cycle load/store-complete pulse.
- bus_error  out  1  sticky; set on watchdog abort, cleared only by reset.
- address  out  32  Avalon address, bits [1:0] always 0.
- read, write  out  1 each  Avalon strobes, never both high.
- writedata  out  32  Avalon write data.
- byteenable  out  4  Avalon lane enables.
- readdata  in  32  Avalon read data.
- waitrequest  in  1  slave stall.

## Operation
- States: IDLE, INSTR, DATA, DONE.
- IDLE: data_write or data_read -> DATA; else instr_req -> INSTR; data wins over a simultaneous fetch. data_read and data_write both high: treated as write.
- On leaving IDLE the bus outputs are registered: address = {addr[31:2],2'b00}; INSTR: read=1, byteenable=4'b1111; DATA: read/write per request, byteenable=data_byteenable, writedata=data_wdata.
- INSTR/DATA: outputs held stable while waitrequest=1. First edge with waitrequest=0 completes: read -> readdata captured into instr_rdata/data_rdata; strobes cleared; matching ready set; -> DONE.
- Watchdog: 7-bit counter (sized to WAIT_TIMEOUT) increments each edge in INSTR/DATA with waitrequest=1, clears on entry. On reaching WAIT_TIMEOUT: strobes cleared, rdata = ABORT_DATA (writes: rdata unchanged), ready pulsed, bus_error set, -> DONE.
- DONE: ready held one cycle, requests ignored, -> IDLE. Guarantees a held request is not re-issued on the completion edge.
- Request inputs sampled only in IDLE; changes during INSTR/DATA have no effect.

## Timing
- Reset values: all outputs 0 (address, writedata, byteenable, rdata included), state IDLE, watchdog 0, bus_error 0.
- Reset mid-transaction: strobes drop immediately (asynchronous); slave must tolerate abandoned transfer.
- Latency with waitrequest=0: request sampled edge E0, strobe high E0..E1, ready high E1..E2, next request sampled at E3. Three cycles per transfer; each waitrequest cycle adds one.
- readdata sampled only on the completing edge (read=1, waitrequest=0).
- instr_ready and data_ready never high together; ready never high for more than one cycle.

## Structure
- Shared package mips_bus_pkg: state enum (IDLE/INSTR/DATA/DONE), BYTEEN_WORD = 4'b1111, default ABORT_DATA constant.
- Single module; no sub-module. The watchdog is an inline counter.

## Test plan
- Fetch 0xBFC00000, slave returns 0x24020005 with waitrequest=0 -> read=1 with address=0xBFC00000 one cycle, instr_ready one cycle with instr_rdata=0x24020005, next fetch accepted 3 cycles after first.
- Simultaneous instr_req and data_write (addr 0x1003, wdata 0x000000AB, be 4'b1000) -> write with address 0x1000 issued first, data_ready, then fetch.
- Load with waitrequest held high 5 cycles -> address/read stable throughout, data_ready 6 cycles after strobe, data_rdata equals readdata at release.
- waitrequest stuck high, WAIT_TIMEOUT=8 -> strobes drop after 8 stall edges, data_rdata=0xDEADBEEF, data_ready pulse, bus_error=1 until reset.
- Assert reset while read=1 and waitrequest=1 -> read, ready and address 0 immediately; after release, state IDLE and a new fetch completes normally.
- instr_req held high across completion -> exactly one bus read per 3 cycles, no duplicate read in the DONE cycle.
